// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, parity modes and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  function automatic int calcDiv(input int clockRate, input int baudRate, input int overSample);
    return clockRate / (baudRate * overSample);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle oversampling strobe every DIV clocks, restartable on a start edge
module uart_baud_tick #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  import uart_pkg::*;
  localparam int DIV = calcDiv(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int CW = $clog2(DIV);
  if (DIV < 2) begin : gDivErr
    $error("uart_baud_tick: clock too slow for baud rate and oversampling");
  end
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority vote, parity and framing checks
module uart_rx_param #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic [DATA_BITS-1:0] out
);
  import uart_pkg::*;
  localparam int M = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : gParamErr
    $error("uart_rx_param: illegal parameter combination");
  end
  state_t state, stateN;
  logic syncA, s, sPrev, tick, restart, finish, commit, vote, v0, v1, parBad, frmBad, stopCnt;
  logic [SW-1:0] sc;
  logic [BW-1:0] bitCnt;
  logic [DATA_BITS-1:0] sh;
  uart_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE(BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) uTick (
    .clk(clk),
    .reset(reset),
    .restart(restart),
    .tick(tick)
  );
  assign commit = tick && sc == SW'(M + 1);
  assign vote = (v0 & v1) | (v0 & s) | (v1 & s);
  assign busy = state inside {START, DATA, uart_pkg::PARITY, STOP};
  assign err = parityErr | frameErr;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= stateN;
  always_comb begin
    stateN = state;
    restart = 1'b0;
    finish = 1'b0;
    if (state != IDLE && !en) stateN = IDLE;
    else
      case (state)
        IDLE: if (en && sPrev && !s) begin
          stateN = START;
          restart = 1'b1;
        end
        START: if (commit) stateN = vote ? IDLE : DATA;
        DATA: if (commit && bitCnt == BW'(DATA_BITS - 1))
          stateN = PARITY == PARITY_NONE ? STOP : uart_pkg::PARITY;
        uart_pkg::PARITY: if (commit) stateN = STOP;
        STOP: if (commit && stopCnt == 1'(STOP_BITS - 1)) begin
          finish = 1'b1;
          stateN = (frmBad || !vote) ? BREAK : IDLE;
        end
        BREAK: if (s) stateN = IDLE;
        default: stateN = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      syncA <= 1'b1;
      s <= 1'b1;
      sPrev <= 1'b1;
      done <= 1'b0;
      sc <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      bitCnt <= '0;
      stopCnt <= 1'b0;
      parBad <= 1'b0;
      frmBad <= 1'b0;
      sh <= '0;
      out <= '0;
      parityErr <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      syncA <= in;
      s <= syncA;
      sPrev <= s;
      done <= finish;
      if (restart) sc <= '0;
      else if (tick) sc <= sc == SW'(OVERSAMPLE - 1) ? '0 : sc + 1'b1;
      if (tick && sc == SW'(M - 1)) v0 <= s;
      if (tick && sc == SW'(M)) v1 <= s;
      if (restart) begin
        bitCnt <= '0;
        stopCnt <= 1'b0;
        parBad <= 1'b0;
        frmBad <= 1'b0;
      end
      if (commit && state == DATA) begin
        sh <= {vote, sh[DATA_BITS-1:1]};
        bitCnt <= bitCnt + 1'b1;
      end
      if (commit && state == uart_pkg::PARITY)
        parBad <= PARITY == PARITY_ODD ? ~(^sh ^ vote) : (^sh ^ vote);
      if (commit && state == STOP) begin
        frmBad <= frmBad | ~vote;
        stopCnt <= stopCnt + 1'b1;
      end
      if (finish) begin
        out <= sh;
        parityErr <= parBad;
        frameErr <= frmBad | ~vote;
      end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against 8N1, 7E1 and 8N2 receivers
module tb_uart_rx_param;
  localparam int CR = 1536000;
  localparam int BIT = 160;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic [2:0] lines = '1;
  logic busy0, done0, err0, pe0, fe0, busy1, done1, err1, pe1, fe1, busy2, done2, err2, pe2, fe2;
  logic [7:0] out0, out2;
  logic [6:0] out1;
  int nv = 0;
  int errs = 0;
  int dc0 = 0, dc1 = 0, dc2 = 0, bc0 = 0;
  always #5 clk = ~clk;
  uart_rx_param #(.CLOCK_RATE(CR)) u8n1 (
    .clk(clk), .reset(reset), .en(en), .in(lines[0]), .busy(busy0), .done(done0),
    .err(err0), .parityErr(pe0), .frameErr(fe0), .out(out0));
  uart_rx_param #(.CLOCK_RATE(CR), .DATA_BITS(7), .PARITY(2)) u7e1 (
    .clk(clk), .reset(reset), .en(en), .in(lines[1]), .busy(busy1), .done(done1),
    .err(err1), .parityErr(pe1), .frameErr(fe1), .out(out1));
  uart_rx_param #(.CLOCK_RATE(CR), .STOP_BITS(2)) u8n2 (
    .clk(clk), .reset(reset), .en(en), .in(lines[2]), .busy(busy2), .done(done2),
    .err(err2), .parityErr(pe2), .frameErr(fe2), .out(out2));
  always @(negedge clk) begin
    if (done0) dc0++;
    if (done1) dc1++;
    if (done2) dc2++;
    if (busy0) bc0++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nv++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int idx, input logic v, input int n);
    lines[idx] = v;
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [15:0] mk(input logic [8:0] d, input int nd, input int par, input int ns, input logic stopLvl);
    logic [15:0] f = '1;
    int p = 1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[p++] = d[i];
    if (par >= 0) f[p++] = par[0];
    for (int i = 0; i < ns; i++) f[p++] = stopLvl;
    return f;
  endfunction
  task automatic sendBits(input int idx, input logic [15:0] bits, input int n, input int hookBit,
                          input int hookKind, input int glitchBit);
    for (int i = 0; i < n; i++) begin
      if (i == hookBit && hookKind == 1) en = 1'b0;
      if (i == hookBit && hookKind == 2) begin
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_pe", pe0, 0);
        chk("midrst_fe", fe0, 0);
        chk("midrst_out", out0, 0);
      end
      if (i == glitchBit) begin
        drive(idx, 1'b1, 87);
        drive(idx, 1'b0, 6);
        drive(idx, 1'b1, BIT - 93);
      end else drive(idx, bits[i], BIT);
    end
  endtask
  initial begin
    int d, b;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_pe", pe0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_out", out0, 0);
    reset = 1'b0;
    drive(0, 1'b1, 40);
    d = dc0;
    b = bc0;
    sendBits(0, mk(9'h55, 8, -1, 1, 1'b1), 10, -1, 0, -1);
    drive(0, 1'b1, 20);
    chk("8n1_done", dc0 - d, 1);
    chk("8n1_out", out0, 8'h55);
    chk("8n1_err", err0, 0);
    chk("8n1_busylen", 32'(bc0 - b >= 1530 && bc0 - b <= 1550), 1);
    d = dc1;
    sendBits(1, mk(9'h41, 7, 0, 1, 1'b1), 10, -1, 0, -1);
    drive(1, 1'b1, 20);
    chk("7e1_done", dc1 - d, 1);
    chk("7e1_out", out1, 7'h41);
    chk("7e1_pe", pe1, 0);
    sendBits(1, mk(9'h41, 7, 1, 1, 1'b1), 10, -1, 0, -1);
    drive(1, 1'b1, 20);
    chk("7e1bad_done", dc1 - d, 2);
    chk("7e1bad_out", out1, 7'h41);
    chk("7e1bad_pe", pe1, 1);
    chk("7e1bad_err", err1, 1);
    chk("7e1bad_fe", fe1, 0);
    d = dc0;
    sendBits(0, mk(9'hF0, 8, -1, 1, 1'b0), 10, -1, 0, -1);
    b = bc0;
    drive(0, 1'b0, 400);
    chk("brk_done", dc0 - d, 1);
    chk("brk_fe", fe0, 1);
    chk("brk_err", err0, 1);
    chk("brk_out", out0, 8'hF0);
    chk("brk_nobusy", bc0 - b, 0);
    drive(0, 1'b1, 100);
    sendBits(0, mk(9'h5A, 8, -1, 1, 1'b1), 10, -1, 0, -1);
    drive(0, 1'b1, 20);
    chk("postbrk_done", dc0 - d, 2);
    chk("postbrk_out", out0, 8'h5A);
    chk("postbrk_fe", fe0, 0);
    sendBits(0, mk(9'hC3, 8, -1, 1, 1'b1), 10, -1, 0, 9);
    drive(0, 1'b1, 20);
    chk("glitch_done", dc0 - d, 3);
    chk("glitch_out", out0, 8'hC3);
    chk("glitch_fe", fe0, 0);
    b = bc0;
    drive(0, 1'b0, 30);
    drive(0, 1'b1, 200);
    chk("fs_busyrose", 32'(bc0 - b > 0), 1);
    chk("fs_busyfell", busy0, 0);
    chk("fs_nodone", dc0 - d, 3);
    chk("fs_out", out0, 8'hC3);
    chk("fs_err", err0, 0);
    d = dc2;
    sendBits(2, mk(9'hA3, 8, -1, 2, 1'b1), 11, -1, 0, -1);
    chk("b2b_first", out2, 8'hA3);
    sendBits(2, mk(9'h3C, 8, -1, 2, 1'b1), 11, -1, 0, -1);
    drive(2, 1'b1, 20);
    chk("b2b_done", dc2 - d, 2);
    chk("b2b_second", out2, 8'h3C);
    chk("b2b_err", err2, 0);
    d = dc0;
    en = 1'b0;
    b = bc0;
    sendBits(0, mk(9'h11, 8, -1, 1, 1'b1), 10, -1, 0, -1);
    drive(0, 1'b1, 20);
    chk("endis_nobusy", bc0 - b, 0);
    chk("endis_nodone", dc0 - d, 0);
    en = 1'b1;
    drive(0, 1'b1, 20);
    sendBits(0, mk(9'h69, 8, -1, 1, 1'b1), 10, 5, 1, -1);
    drive(0, 1'b1, 20);
    chk("enab_nodone", dc0 - d, 0);
    chk("enab_busy", busy0, 0);
    chk("enab_out", out0, 8'hC3);
    en = 1'b1;
    drive(0, 1'b1, 20);
    sendBits(0, mk(9'h96, 8, -1, 1, 1'b1), 10, -1, 0, -1);
    drive(0, 1'b1, 20);
    chk("enab_next_done", dc0 - d, 1);
    chk("enab_next_out", out0, 8'h96);
    sendBits(0, mk(9'h69, 8, -1, 1, 1'b1), 10, 5, 2, -1);
    reset = 1'b0;
    drive(0, 1'b1, 40);
    chk("rstab_nodone", dc0 - d, 1);
    chk("rstab_out", out0, 0);
    sendBits(0, mk(9'h96, 8, -1, 1, 1'b1), 10, -1, 0, -1);
    drive(0, 1'b1, 20);
    chk("rstab_next_done", dc0 - d, 2);
    chk("rstab_next_out", out0, 8'h96);
    chk("rstab_next_err", err0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, errs);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 Uart8 rx path. Configurable data width, parity mode, stop-bit count and oversampling ratio. Majority-vote bit sampling, false-start rejection, separate parity and framing error flags. Sits between the board rx pin and the byte-level consumer; the tx path is a separate block.

Parameters:
CLOCK_RATE, 12000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit; even, >= 8

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  receive enable
in  in  1  serial line, asynchronous to clk, idle high
busy  out  1  frame in progress
done  out  1  one-cycle pulse when a frame completes
err  out  1  parityErr OR frameErr
parityErr  out  1  parity mismatch on last frame
frameErr  out  1  stop bit sampled low on last frame
out  out  DATA_BITS  received data, LSB first on the line

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, err=0, parityErr=0, frameErr=0, out=0, synchroniser flops=1, state=IDLE, counters=0.
- `in` passes through a 2-flop synchroniser; all logic uses the synchronised value `s`.
- Tick divider: DIV = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE), truncated. Elaboration error if DIV < 2. Tick is a one-cycle strobe every DIV clocks. The divider runs freely but restarts at 0 on start-edge detection.
- Sample counter `sc` counts 0..OVERSAMPLE-1 on ticks and wraps. Bit value is the majority of `s` at sc = M-1, M and M+1, where M = OVERSAMPLE/2. The bit is committed at sc = M+1.
- States:
  - IDLE: wait for `en` and a falling edge of `s`; then clear sc and enter START; busy=1.
  - START: voted start bit = 1 -> false start: return to IDLE, busy=0, no done, flags unchanged. Voted 0 -> DATA.
  - DATA: shift DATA_BITS voted bits LSB first, one per bit period (sc wrap). Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: voted bit is compared with the computed parity (odd: XOR of data bits and parity bit = 1; even: = 0). Store the mismatch.
  - STOP: vote each stop bit; any low vote sets the frame error. After the commit point of the last stop bit: update out, parityErr, frameErr and err, and pulse done for exactly one cycle. busy falls in the same cycle. If frameErr=1, go to BREAK; else go to IDLE.
  - BREAK: wait until `s` = 1 (line break or glitched stop), then go to IDLE.
- Receiver is ready for the next start edge immediately after the last stop-bit commit. The second half of the stop bit is not required.
- out, parityErr and frameErr hold until the next done. They are never cleared by a new start.
- A short low glitch within a stop bit that covers at most one of the three vote samples must not set frameErr.
- en deasserted mid-frame: abort to IDLE in the next cycle, busy=0, no done, outputs unchanged.
- en deasserted in IDLE: start edges are ignored.
- reset mid-frame: all state and outputs return to their reset values immediately.
- Falling edges are ignored unless the state is IDLE.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), parity-mode constants PARITY_NONE/ODD/EVEN, and a function computing DIV.
- One sub-module, uart_baud_tick: tick divider with a synchronous restart input, parameterised by CLOCK_RATE, BAUD_RATE and OVERSAMPLE. It is shared with the future tx block.

Test Plan:
- Default 8N1, byte 0x55 at 9600 baud -> one done pulse, out=0x55, err=0, busy high for about 9.5 bit times.
- PARITY=2, DATA_BITS=7, byte 0x41 with parity bit 0 -> out=0x41, parityErr=0. Same frame with parity bit 1 -> parityErr=1, err=1, done pulses.
- Stop bit low for a full bit (break) -> frameErr=1, done pulses, no new frame accepted until the line returns high. A one-sample low glitch in the stop bit -> frameErr=0.
- Low pulse of 3/16 of a bit on an idle line -> busy rises then falls, no done, flags unchanged.
- STOP_BITS=2, back-to-back frames 0xA3 then 0x3C with no idle gap -> two done pulses, out values correct in order.
- en dropped at data bit 4, and separately reset asserted at data bit 4 -> no done; reset case shows all outputs 0; the following full frame 0x96 is received correctly.
